// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: MODE encodings and FSM states shared by univ_shift_reg and its bench.
package univ_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// shift_cnt: burst shift counter; tc flags the step whose increment reaches WIDTH.
module shift_cnt
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    // Parks at WIDTH after the final step; only a new load clears it, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + CW'(1);
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with manual modes and an automatic
// load-then-shift-out burst (LSB first on SOUT).
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN_L,
    input  logic             SIN_R,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_manual;
    logic             load;
    logic             step;
    logic             tc;

    assign load = EN && (state == ST_IDLE) && START;
    assign step = EN && (state == ST_SHIFT);

    shift_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (CLK),
        .rst_n (CLR),
        .clr   (load),
        .inc   (step),
        .tc    (tc)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = load ? ST_SHIFT : (step && tc) ? ST_IDLE : state;
    end

    always_comb begin
        BUSY = (state == ST_SHIFT);
        SOUT = Q[0];
    end

    always_comb begin
        q_manual = (MODE == MODE_SHR)  ? {SIN_L, Q[WIDTH-1:1]} :
                   (MODE == MODE_SHL)  ? {Q[WIDTH-2:0], SIN_R} :
                   (MODE == MODE_LOAD) ? D : Q;
        q_nxt    = load ? D :
                   step ? {SIN_L, Q[WIDTH-1:1]} :
                   (EN && state == ST_IDLE) ? q_manual : Q;
    end

    // DONE is refreshed every edge so the pulse ends even while EN is low.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q    <= RST_VAL;
            DONE <= 1'b0;
        end else begin
            Q    <= q_nxt;
            DONE <= step && tc;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scenario tasks with a SOUT scoreboard for univ_shift_reg (WIDTH=8).
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    localparam int W = 8;

    logic         CLK;
    logic         CLR;
    logic         EN;
    logic [1:0]   MODE;
    logic [W-1:0] D;
    logic         SIN_L;
    logic         SIN_R;
    logic         START;
    logic [W-1:0] Q;
    logic         SOUT;
    logic         BUSY;
    logic         DONE;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic obs_q[$];

    univ_shift_reg #(.WIDTH(W), .RST_VAL({W{1'b0}})) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .EN    (EN),
        .MODE  (MODE),
        .D     (D),
        .SIN_L (SIN_L),
        .SIN_R (SIN_R),
        .START (START),
        .Q     (Q),
        .SOUT  (SOUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_bits(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) exp_q.push_back(v[i]);
    endtask

    // Runs a burst to its DONE cycle, recording SOUT on every cycle that will shift.
    task automatic drain(input int stall_at, input int stall_len, input int pulse_at,
                         output int busy_n, output int done_n, output logic [W-1:0] q_done);
        busy_n = 0;
        done_n = 0;
        q_done = 'x;
        for (int k = 0; k < 40; k++) begin
            if (DONE) begin
                done_n++;
                q_done = Q;
                break;
            end
            if (BUSY) busy_n++;
            EN    = !(k >= stall_at && k < stall_at + stall_len);
            START = (k == pulse_at);
            if (BUSY && EN) obs_q.push_back(SOUT);
            @(negedge CLK);
        end
        EN    = 1'b1;
        START = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b0; EN = 1'b0; MODE = MODE_HOLD; D = '0;
        SIN_L = 1'b0; SIN_R = 1'b0; START = 1'b0;
        #1;
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", Q); end
        checks++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {BUSY, DONE}); end
        @(negedge CLK);
        CLR = 1'b1; EN = 1'b1; MODE = MODE_LOAD; D = 8'hA5;
        @(negedge CLK);
        MODE = MODE_HOLD;
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL preload_a5 got %h want a5", Q); end
        #2 CLR = 1'b0;
        #1;
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL async_clr_q got %h want 00", Q); end
        checks++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL async_clr_flags got %b want 00", {BUSY, DONE}); end
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    task automatic test_manual();
        logic [W-1:0] m;
        EN = 1'b1; MODE = MODE_LOAD; D = 8'h3C;
        @(negedge CLK);
        m = 8'h3C;
        checks++; if (Q !== m) begin errors++; $display("FAIL mode_load got %h want %h", Q, m); end
        MODE = MODE_SHL; SIN_R = 1'b1;
        @(negedge CLK);
        m = {m[W-2:0], 1'b1};
        checks++; if (Q !== m) begin errors++; $display("FAIL mode_shl got %h want %h", Q, m); end
        MODE = MODE_SHR; SIN_L = 1'b1;
        @(negedge CLK);
        m = {1'b1, m[W-1:1]};
        checks++; if (Q !== m) begin errors++; $display("FAIL mode_shr got %h want %h", Q, m); end
        MODE = MODE_HOLD;
        @(negedge CLK);
        checks++; if (Q !== m) begin errors++; $display("FAIL mode_hold got %h want %h", Q, m); end
        EN = 1'b0; MODE = MODE_LOAD; D = 8'h00; START = 1'b1;
        @(negedge CLK);
        checks++; if (Q !== m) begin errors++; $display("FAIL en_low_hold got %h want %h", Q, m); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL en_low_start got busy %b want 0", BUSY); end
        EN = 1'b1; START = 1'b0; MODE = MODE_HOLD; SIN_L = 1'b0; SIN_R = 1'b0;
    endtask

    task automatic test_burst();
        int busy_n, done_n;
        logic [W-1:0] q_done;
        logic e, o;
        SIN_L = 1'b0; MODE = MODE_SHL; D = 8'hB4; START = 1'b1;
        push_bits(D);
        @(negedge CLK);
        checks++; if (BUSY !== 1'b1 || Q !== 8'hB4) begin errors++; $display("FAIL burst_start got busy %b q %h want 1 b4", BUSY, Q); end
        drain(-1, 0, -1, busy_n, done_n, q_done);
        MODE = MODE_HOLD;
        checks++; if (busy_n != W) begin errors++; $display("FAIL burst_busy_len got %0d want %0d", busy_n, W); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL burst_done got %0d want 1", done_n); end
        checks++; if (q_done !== {W{1'b0}}) begin errors++; $display("FAIL burst_q_end got %h want 00", q_done); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
            checks++; if (o !== e) begin errors++; $display("FAIL burst_sout[%0d] got %b want %b", i, o, e); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL burst_extra_bits got %0d want 0", obs_q.size()); end
        obs_q.delete();
        EN = 1'b0;
        @(negedge CLK);
        checks++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL done_pulse_en_low got %b want 00", {BUSY, DONE}); end
        EN = 1'b1;
    endtask

    task automatic test_stall();
        int busy_n, done_n;
        logic [W-1:0] q_done;
        logic e, o;
        SIN_L = 1'b0; D = 8'hFF; START = 1'b1;
        push_bits(D);
        @(negedge CLK);
        drain(3, 3, -1, busy_n, done_n, q_done);
        checks++; if (busy_n != W + 3) begin errors++; $display("FAIL stall_busy_len got %0d want %0d", busy_n, W + 3); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_n); end
        checks++; if (q_done !== {W{1'b0}}) begin errors++; $display("FAIL stall_q_end got %h want 00", q_done); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
            checks++; if (o !== e) begin errors++; $display("FAIL stall_sout[%0d] got %b want %b", i, o, e); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL stall_extra_bits got %0d want 0", obs_q.size()); end
        obs_q.delete();
        @(negedge CLK);
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL stall_single_done got %b want 0", DONE); end
    endtask

    task automatic test_back_to_back();
        int busy_n, done_n;
        logic [W-1:0] q_done;
        logic e, o;
        SIN_L = 1'b1; D = 8'h96; START = 1'b1;
        push_bits(D);
        @(negedge CLK);
        drain(-1, 0, 2, busy_n, done_n, q_done);
        checks++; if (busy_n != W || done_n != 1) begin errors++; $display("FAIL b2b_first got busy %0d done %0d want %0d 1", busy_n, done_n, W); end
        checks++; if (q_done !== {W{1'b1}}) begin errors++; $display("FAIL b2b_first_q got %h want ff", q_done); end
        D = 8'h5A; START = 1'b1;
        push_bits(D);
        @(negedge CLK);
        checks++; if (BUSY !== 1'b1 || Q !== 8'h5A || DONE !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy %b q %h done %b want 1 5a 0", BUSY, Q, DONE); end
        drain(-1, 0, -1, busy_n, done_n, q_done);
        checks++; if (busy_n != W || done_n != 1) begin errors++; $display("FAIL b2b_second got busy %0d done %0d want %0d 1", busy_n, done_n, W); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz;
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_sout[%0d] got %b want %b", i, o, e); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra_bits got %0d want 0", obs_q.size()); end
        obs_q.delete();
        @(negedge CLK);
        checks++; if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b want 00", {BUSY, DONE}); end
        SIN_L = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        SIN_L = 1'b0; D = 8'hC3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL abort_mid_busy got %b want 1", BUSY); end
        #2 CLR = 1'b0;
        #1;
        checks++; if (Q !== 8'h00 || {BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL abort_clr got q %h flags %b want 00 00", Q, {BUSY, DONE}); end
        MODE = MODE_SHL; SIN_R = 1'b1;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        checks++; if (Q !== 8'h01 || BUSY !== 1'b0) begin errors++; $display("FAIL abort_first_edge got q %h busy %b want 01 0", Q, BUSY); end
        MODE = MODE_HOLD; SIN_R = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE || BUSY) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_burst();
        test_stall();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
